ma_brk_ctl: RTL and testbench
=============================

// Module: ma_brk_ctl
// PURPOSE
//  Parametrised multi-channel data-break (DMA) controller placed between the
//  peripherals and the shared memory port; the CPU address path hands the port
//  over while brk_active is high. Supersedes the single-channel RK8E break
//  path. Adds round-robin arbitration across NCH channels and per-channel
//  PDP-8 three-cycle break mode (word count and current address kept in
//  field-0 memory). Vectors are big-endian ([0:N-1], bit 0 = MSB), per codebase.
// PARAMETERS
//  NCH      2         number of break channels (1..8)
//  AW       15        extended address width: 3-bit field + 12-bit word address
//  DW       12        data word width
//  TC_MASK  {NCH{0}}  bit i set = channel i uses three-cycle mode (bit 0 = chan 0)
// PORTS
//  clk        in   1       system clock
//  reset      in   1       asynchronous, active-low reset
//  break_ok   in   1       CPU at a cycle boundary; a break may start
//  req        in   NCH     break request, level, one bit per channel
//  wr         in   NCH     1 = device->memory write, 0 = memory->device read
//  addr       in   NCH*AW  1-cycle: data address; 3-cycle: low 12 bits = WC pointer
//  wdata      in   NCH*DW  write data per channel
//  mem_rdata  in   DW      memory read data, valid 1 cycle after address
//  gnt        out  NCH     one-hot, channel currently served
//  done       out  NCH     one-cycle pulse, transfer of that channel complete
//  ovf        out  NCH     one-cycle pulse with done: word count wrapped to 0
//  rdata      out  DW      read data returned to the device, valid with done
//  brk_active out  1       controller owns the memory port; CPU must hold
//  mem_addr   out  AW      memory address
//  mem_wdata  out  DW      memory write data
//  mem_we     out  1       memory write strobe, one cycle
// BEHAVIOUR
//  Reset (async, low): state IDLE; all outputs 0; rr_ptr=0. Any transfer in
//   flight is aborted, mem_we drops immediately, and no done/ovf is issued.
//  Packing: channel i occupies addr[i*AW +: AW] and wdata[i*DW +: DW].
//  Arbitration (IDLE, break_ok=1, |req): winner = first requester at or after
//   rr_ptr, wrapping; rr_ptr <= winner+1 mod NCH. Winner's wr/addr/wdata are
//   latched; gnt and brk_active set on the next edge. Later changes to the
//   latched request are ignored until done.
//  FSM, one state per clock:
//   IDLE -> WC0 (TC_MASK[win]) or DA (otherwise)
//   WC0: mem_addr={3'o0,ptr}            WC1: wait
//   WC2: mem_wdata=mem_rdata+1, mem_we=1; result==0 -> ovf_flag
//   CA0: mem_addr={3'o0,ptr+1}          CA1: wait
//   CA2: ca=mem_rdata+1; write ca back (mem_we=1); data addr={addr[0:2],ca}
//   DA: mem_addr=data addr; if wr: mem_wdata=wdata, mem_we=1
//   DW: wait        DR: if !wr: rdata<=mem_rdata; done[win]=1, ovf[win]=ovf_flag
//   DR -> IDLE; gnt, brk_active clear on same edge as done.
//  Latency from grant: 1-cycle mode 3 clocks; three-cycle mode 9 clocks.
//  Arithmetic: all +1 operations are 12-bit modulo: 7777+1=0000. The field
//   never carries (ptr=7777 -> CA at 0000 of field 0; ca wraps within field).
//  break_ok is only sampled in IDLE; deassertion mid-break has no effect.
//  At most one mem_we per clock; mem_we never high in IDLE, WC0/1, CA0/1, DW, DR.
//  Back-to-back: a still-pending req is re-arbitrated in the first IDLE cycle
//   after done; at least one IDLE cycle lies between breaks (CPU progress).
//  rdata holds its value until the next read completion.
// TESTING
//  1: ch0 1-cycle write, addr=15'o12345, wdata=o7070 -> mem o2345/field1 = o7070, done[0] 3 clk after gnt
//  2: ch1 1-cycle read of preloaded o4321 at o00200 -> rdata=o4321 with done[1], mem_we never high
//  3: req=2'b11 held, rr_ptr=0 -> grants ch0, ch1, ch0 in sequence, each with one IDLE gap
//  4: ch0 three-cycle, ptr=o0030, M[30]=o7777, M[31]=o0477, field 2, write o1111
//     -> M[30]=o0000, M[31]=o0500, M[2:0500]=o1111, ovf[0] with done at clk 9
//  5: ptr=o7777 wrap: CA read from 0:0000, incremented, written back; WC not wrapped -> ovf=0
//  6: reset low during WC2 of test 4 -> mem_we=0 at once, no done, idle after release

Source files
------------

// File: rtl/ma_brk_ctl_if.sv
// Bus bundle for the multi-channel data-break controller: the peripheral
// request side plus the shared memory port. Vectors are big-endian (bit 0 is
// the MSB); channel i occupies addr[i*AW +: AW] and wdata[i*DW +: DW].
interface ma_brk_ctl_if #(
  parameter int NCH = 2,
  parameter int AW  = 15,
  parameter int DW  = 12
);

  // Peripheral side
  logic               break_ok;
  logic [0:NCH-1]     req;
  logic [0:NCH-1]     wr;
  logic [0:NCH*AW-1]  addr;
  logic [0:NCH*DW-1]  wdata;
  logic [0:NCH-1]     gnt;
  logic [0:NCH-1]     done;
  logic [0:NCH-1]     ovf;
  logic [0:DW-1]      rdata;
  logic               brk_active;

  // Memory port side
  logic [0:AW-1]      mem_addr;
  logic [0:DW-1]      mem_wdata;
  logic               mem_we;
  logic [0:DW-1]      mem_rdata;

  // Controller view
  modport master (
    input  break_ok, req, wr, addr, wdata, mem_rdata,
    output gnt, done, ovf, rdata, brk_active, mem_addr, mem_wdata, mem_we
  );

  // Environment view (peripherals, CPU hold logic and memory)
  modport slave (
    output break_ok, req, wr, addr, wdata, mem_rdata,
    input  gnt, done, ovf, rdata, brk_active, mem_addr, mem_wdata, mem_we
  );

endinterface

// File: rtl/ma_brk_ctl.sv
// Multi-channel data-break (DMA) controller. Arbitrates round-robin between
// NCH break channels and runs either a single-cycle break (direct data
// address) or a PDP-8 three-cycle break (word count and current address kept
// in field-0 memory, both incremented in place) on the shared memory port.
// The CPU holds off the memory port while brk_active is high.
module ma_brk_ctl #(
  parameter int             NCH     = 2,
  parameter int             AW      = 15,
  parameter int             DW      = 12,
  parameter logic [0:NCH-1] TC_MASK = '0
) (
  input  logic         clk,
  input  logic         reset,
  ma_brk_ctl_if.master bus
);

  // Word address width inside a field; the remaining high bits are the field.
  localparam int WAW = 12;
  localparam int FW  = AW - WAW;
  localparam int PW  = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_WC0  = 4'd1;
  localparam logic [3:0] ST_WC1  = 4'd2;
  localparam logic [3:0] ST_WC2  = 4'd3;
  localparam logic [3:0] ST_CA0  = 4'd4;
  localparam logic [3:0] ST_CA1  = 4'd5;
  localparam logic [3:0] ST_CA2  = 4'd6;
  localparam logic [3:0] ST_DA   = 4'd7;
  localparam logic [3:0] ST_DW   = 4'd8;
  localparam logic [3:0] ST_DR   = 4'd9;

  logic [3:0]      state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   win_ch;
  logic            lat_wr;
  logic [0:FW-1]   lat_field;
  logic [0:WAW-1]  lat_ptr;
  logic [0:DW-1]   lat_wdata;
  logic            ovf_flag;

  logic [0:NCH-1]  gnt_q;
  logic [0:NCH-1]  done_q;
  logic [0:NCH-1]  ovf_q;
  logic [0:DW-1]   rdata_q;
  logic            brk_q;
  logic [0:AW-1]   mem_addr_q;

  logic            mem_we_c;
  logic [0:DW-1]   mem_wdata_c;

  logic            arb_found;
  logic [PW-1:0]   arb_ch;
  logic            sel_wr;
  logic [0:AW-1]   sel_addr;
  logic [0:DW-1]   sel_wdata;

  logic [0:WAW-1]  ptr_inc;
  logic [0:DW-1]   rdata_inc;
  logic [0:WAW-1]  ca_next;

  // Channel number 'offset' places after 'base', wrapping modulo NCH.
  function automatic logic [PW-1:0] chan_at(input logic [PW-1:0] base, input int offset);
    int sum;
    sum = (int'(base) + offset) % NCH;
    return PW'(sum);
  endfunction

  // One-hot channel vector, bit 0 = channel 0.
  function automatic logic [0:NCH-1] onehot(input logic [PW-1:0] ch);
    logic [0:NCH-1] r;
    r = '0;
    for (int k = 0; k < NCH; k++) begin
      if (PW'(k) == ch) begin
        r[k] = 1'b1;
      end
    end
    return r;
  endfunction

  // All increments are 12-bit modulo; the field never takes a carry.
  assign ptr_inc   = lat_ptr + WAW'(1);
  assign rdata_inc = bus.mem_rdata + DW'(1);
  assign ca_next   = WAW'(rdata_inc);

  // Round-robin search: first requester at or after rr_ptr, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_ch    = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!arb_found && bus.req[chan_at(rr_ptr, k)]) begin
        arb_found = 1'b1;
        arb_ch    = chan_at(rr_ptr, k);
      end
    end
  end

  // Pick out the winning channel's direction, address and write data.
  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 0; k < NCH; k++) begin
      if (PW'(k) == arb_ch) begin
        sel_wr    = bus.wr[k];
        sel_addr  = bus.addr[k*AW +: AW];
        sel_wdata = bus.wdata[k*DW +: DW];
      end
    end
  end

  // Memory write strobe and data follow the current state directly, so a
  // reset removes them at once; IDLE and the wait states never write.
  always_comb begin
    mem_we_c    = 1'b0;
    mem_wdata_c = '0;
    case (state)
      ST_WC2, ST_CA2: begin
        mem_we_c    = 1'b1;
        mem_wdata_c = rdata_inc;
      end
      ST_DA: begin
        if (lat_wr) begin
          mem_we_c    = 1'b1;
          mem_wdata_c = lat_wdata;
        end
      end
      default: begin
        mem_we_c    = 1'b0;
        mem_wdata_c = '0;
      end
    endcase
  end

  // Break sequencer: arbitration, request latching, address generation and
  // grant ownership. mem_addr is registered and held for the whole
  // address/wait/use triple so the synchronous memory returns matching data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      win_ch     <= '0;
      lat_wr     <= 1'b0;
      lat_field  <= '0;
      lat_ptr    <= '0;
      lat_wdata  <= '0;
      ovf_flag   <= 1'b0;
      gnt_q      <= '0;
      brk_q      <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.break_ok && arb_found) begin
            win_ch    <= arb_ch;
            rr_ptr    <= chan_at(arb_ch, 1);
            lat_wr    <= sel_wr;
            lat_field <= sel_addr[0:FW-1];
            lat_ptr   <= sel_addr[FW:AW-1];
            lat_wdata <= sel_wdata;
            ovf_flag  <= 1'b0;
            gnt_q     <= onehot(arb_ch);
            brk_q     <= 1'b1;
            if (TC_MASK[arb_ch]) begin
              state      <= ST_WC0;
              mem_addr_q <= {FW'(0), sel_addr[FW:AW-1]};
            end else begin
              state      <= ST_DA;
              mem_addr_q <= sel_addr;
            end
          end
        end
        ST_WC0: state <= ST_WC1;
        ST_WC1: state <= ST_WC2;
        ST_WC2: begin
          ovf_flag   <= (rdata_inc == '0);
          mem_addr_q <= {FW'(0), ptr_inc};
          state      <= ST_CA0;
        end
        ST_CA0: state <= ST_CA1;
        ST_CA1: state <= ST_CA2;
        ST_CA2: begin
          mem_addr_q <= {lat_field, ca_next};
          state      <= ST_DA;
        end
        ST_DA:  state <= ST_DW;
        ST_DW:  state <= ST_DR;
        ST_DR: begin
          gnt_q      <= '0;
          brk_q      <= 1'b0;
          mem_addr_q <= '0;
          state      <= ST_IDLE;
        end
        default: begin
          gnt_q      <= '0;
          brk_q      <= 1'b0;
          mem_addr_q <= '0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

  // Completion: one-cycle done/ovf pulses and read-data capture on leaving
  // DR; rdata keeps its value until the next read finishes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q  <= '0;
      ovf_q   <= '0;
      rdata_q <= '0;
    end else begin
      done_q <= '0;
      ovf_q  <= '0;
      if (state == ST_DR) begin
        done_q <= onehot(win_ch);
        if (ovf_flag) begin
          ovf_q <= onehot(win_ch);
        end
        if (!lat_wr) begin
          rdata_q <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.done       = done_q;
  assign bus.ovf        = ovf_q;
  assign bus.rdata      = rdata_q;
  assign bus.brk_active = brk_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_c;
  assign bus.mem_we     = mem_we_c;

endmodule

// File: tb/tb_ma_brk_ctl.sv
// Self-checking bench for ma_brk_ctl: three channels, channels 0 and 1 in
// single-cycle mode, channel 2 in three-cycle mode. A synchronous memory
// model sits on the memory port. Table vectors are pushed to a scoreboard
// when driven and popped when done appears; hand sequences cover
// round-robin back-to-back breaks and reset in the middle of a break.
module tb_ma_brk_ctl;

  localparam int NCH = 3;
  localparam int AW  = 15;
  localparam int DW  = 12;

  typedef struct {
    int          ch;
    bit          tc;
    bit          wr;
    logic [0:14] addr;
    logic [0:11] wdata;
    logic [0:11] data_init;
    logic [0:14] wc_addr;
    logic [0:11] wc_init;
    logic [0:11] exp_wc;
    logic [0:14] ca_addr;
    logic [0:11] ca_init;
    logic [0:11] exp_ca;
    logic [0:14] exp_daddr;
    logic [0:11] exp_mem;
    logic [0:11] exp_rdata;
    bit          exp_ovf;
    int          exp_lat;
    int          exp_we;
  } vec_t;

  logic clk;
  logic reset;

  ma_brk_ctl_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus ();

  ma_brk_ctl #(
    .NCH     (NCH),
    .AW      (AW),
    .DW      (DW),
    .TC_MASK (3'b001)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [0:11] mem [0:32767];
  logic        pl_en;
  logic [0:14] pl_addr;
  logic [0:11] pl_data;

  int   cycle;
  int   we_count;
  int   done_count;
  int   checks;
  int   passed;
  int   g_cycle;
  vec_t sb_q[$];
  vec_t vecs[7];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: read-old, one-cycle read latency, plus a preload path.
  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  // Free-running cycle count and activity counters.
  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    if (bus.mem_we) we_count <= we_count + 1;
    if (|bus.done) done_count <= done_count + 1;
  end

  function automatic logic [0:NCH-1] onehot(input int ch);
    logic [0:NCH-1] r;
    r = '0;
    r[ch] = 1'b1;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %0o, expected %0o", name, actual, expected);
    end else begin
      passed++;
    end
  endtask

  task automatic preload(input logic [0:14] a, input logic [0:11] d);
    @(negedge clk);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(negedge clk);
    pl_en   = 1'b0;
  endtask

  task automatic waitGnt(output int steps, output bit ok);
    steps = 0;
    while (!(|bus.gnt) && steps < 20) begin
      @(negedge clk);
      steps++;
    end
    ok = |bus.gnt;
  endtask

  task automatic waitDone(output bit ok);
    int steps;
    steps = 0;
    while (!(|bus.done) && steps < 30) begin
      @(negedge clk);
      steps++;
    end
    ok = |bus.done;
  endtask

  // Drive one table vector: preload memory, push the expectation, request,
  // then scramble the request lines and drop break_ok once granted.
  task automatic applyStimulus(input vec_t v, output int we_start);
    int  steps;
    bit  ok;
    preload(v.exp_daddr, v.data_init);
    if (v.tc) begin
      preload(v.wc_addr, v.wc_init);
      preload(v.ca_addr, v.ca_init);
    end
    sb_q.push_back(v);
    we_start = we_count;
    @(negedge clk);
    bus.req                   = '0;
    bus.req[v.ch]             = 1'b1;
    bus.wr[v.ch]              = v.wr;
    bus.addr[v.ch*AW +: AW]   = v.addr;
    bus.wdata[v.ch*DW +: DW]  = v.wdata;
    bus.break_ok              = 1'b1;
    waitGnt(steps, ok);
    if (!ok) checkOutput("grant timeout", 32'd0, 32'd1);
    g_cycle = cycle;
    checkOutput("gnt at grant", bus.gnt, onehot(v.ch));
    checkOutput("brk_active at grant", bus.brk_active, 1);
    bus.req                   = '0;
    bus.wr[v.ch]              = ~v.wr;
    bus.addr[v.ch*AW +: AW]   = ~v.addr;
    bus.wdata[v.ch*DW +: DW]  = ~v.wdata;
    bus.break_ok              = 1'b0;
  endtask

  // Wait for completion, pop the scoreboard and compare everything visible.
  task automatic checkResult(input int we_start);
    bit   ok;
    vec_t v;
    waitDone(ok);
    if (!ok) checkOutput("done timeout", 32'd0, 32'd1);
    if (sb_q.size() == 0) begin
      checkOutput("scoreboard empty", 32'd0, 32'd1);
    end else begin
      v = sb_q.pop_front();
      checkOutput("latency", cycle - g_cycle, v.exp_lat);
      checkOutput("done", bus.done, onehot(v.ch));
      checkOutput("ovf", bus.ovf, v.exp_ovf ? onehot(v.ch) : '0);
      checkOutput("rdata", bus.rdata, v.exp_rdata);
      checkOutput("gnt clear with done", bus.gnt, 0);
      checkOutput("brk_active clear", bus.brk_active, 0);
      checkOutput("data word", mem[v.exp_daddr], v.exp_mem);
      checkOutput("mem_we count", we_count - we_start, v.exp_we);
      if (v.tc) begin
        checkOutput("word count", mem[v.wc_addr], v.exp_wc);
        checkOutput("current addr", mem[v.ca_addr], v.exp_ca);
      end
    end
  endtask

  initial begin
    int   we_start;
    int   steps;
    bit   ok;
    vec_t e;
    vec_t v;

    checks = 0; passed = 0; cycle = 0; we_count = 0; done_count = 0; g_cycle = 0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    bus.break_ok = 1'b0; bus.req = '0; bus.wr = '0; bus.addr = '0; bus.wdata = '0;
    reset = 1'b0;

    //        ch tc wr addr       wdata     dinit     wc_addr    wc_init   exp_wc    ca_addr    ca_init   exp_ca    daddr      exp_mem   exp_rdata ovf lat we
    vecs[0] = '{0, 0, 1, 15'o12345, 12'o7070, 12'o0000, 15'o00000, 12'o0000, 12'o0000, 15'o00000, 12'o0000, 12'o0000, 15'o12345, 12'o7070, 12'o0000, 0, 3, 1};
    vecs[1] = '{1, 0, 0, 15'o00200, 12'o0000, 12'o4321, 15'o00000, 12'o0000, 12'o0000, 15'o00000, 12'o0000, 12'o0000, 15'o00200, 12'o4321, 12'o4321, 0, 3, 0};
    vecs[2] = '{1, 0, 1, 15'o77777, 12'o0001, 12'o0000, 15'o00000, 12'o0000, 12'o0000, 15'o00000, 12'o0000, 12'o0000, 15'o77777, 12'o0001, 12'o4321, 0, 3, 1};
    vecs[3] = '{0, 0, 0, 15'o30000, 12'o0000, 12'o5555, 15'o00000, 12'o0000, 12'o0000, 15'o00000, 12'o0000, 12'o0000, 15'o30000, 12'o5555, 12'o5555, 0, 3, 0};
    vecs[4] = '{2, 1, 1, 15'o20030, 12'o1111, 12'o0000, 15'o00030, 12'o7777, 12'o0000, 15'o00031, 12'o0477, 12'o0500, 15'o20500, 12'o1111, 12'o5555, 1, 9, 3};
    vecs[5] = '{2, 1, 0, 15'o37777, 12'o0000, 12'o6543, 15'o07777, 12'o0005, 12'o0006, 15'o00000, 12'o0100, 12'o0101, 15'o30101, 12'o6543, 12'o6543, 0, 9, 2};
    vecs[6] = '{2, 1, 0, 15'o50100, 12'o0000, 12'o2222, 15'o00100, 12'o7776, 12'o7777, 15'o00101, 12'o7777, 12'o0000, 15'o50000, 12'o2222, 12'o2222, 0, 9, 2};

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset gnt", bus.gnt, 0);
    checkOutput("reset done", bus.done, 0);
    checkOutput("reset brk_active", bus.brk_active, 0);
    checkOutput("reset mem_we", bus.mem_we, 0);
    checkOutput("reset mem_addr", bus.mem_addr, 0);
    checkOutput("reset rdata", bus.rdata, 0);
    reset = 1'b1;
    @(negedge clk);

    // Table-driven single transfers
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i], we_start);
      checkResult(we_start);
    end

    // Round-robin with both single-cycle channels held, rr_ptr fresh from reset
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus.wr = '0;
    bus.addr[0*AW +: AW] = 15'o00200;
    bus.addr[1*AW +: AW] = 15'o12345;
    bus.req = 3'b110;
    repeat (4) @(negedge clk);
    checkOutput("no grant without break_ok", bus.gnt, 0);
    bus.break_ok = 1'b1;
    e = vecs[1]; e.ch = 0; e.exp_rdata = 12'o4321; sb_q.push_back(e);
    e.ch = 1; e.exp_rdata = 12'o7070; sb_q.push_back(e);
    e.ch = 0; e.exp_rdata = 12'o4321; sb_q.push_back(e);
    for (int n = 0; n < 3; n++) begin
      waitGnt(steps, ok);
      if (!ok) checkOutput("rr grant timeout", 32'd0, 32'd1);
      if (n > 0) checkOutput("rr idle gap", steps, 1);
      if (sb_q.size() > 0) begin
        checkOutput("rr gnt", bus.gnt, onehot(sb_q[0].ch));
      end
      if (n == 2) bus.req = '0;
      waitDone(ok);
      if (!ok) checkOutput("rr done timeout", 32'd0, 32'd1);
      if (sb_q.size() == 0) begin
        checkOutput("rr scoreboard empty", 32'd0, 32'd1);
      end else begin
        v = sb_q.pop_front();
        checkOutput("rr done", bus.done, onehot(v.ch));
        checkOutput("rr rdata", bus.rdata, v.exp_rdata);
        checkOutput("rr gnt clear", bus.gnt, 0);
      end
    end

    // Reset during WC2 of a three-cycle write
    preload(15'o00030, 12'o7777);
    preload(15'o00031, 12'o0477);
    @(negedge clk);
    bus.req = 3'b001;
    bus.wr[2] = 1'b1;
    bus.addr[2*AW +: AW] = 15'o20030;
    bus.wdata[2*DW +: DW] = 12'o2222;
    bus.break_ok = 1'b1;
    waitGnt(steps, ok);
    if (!ok) checkOutput("abort grant timeout", 32'd0, 32'd1);
    bus.req = '0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("WC2 write strobe", bus.mem_we, 1);
    checkOutput("WC2 write data", bus.mem_wdata, 12'o0000);
    #1 reset = 1'b0;
    #1;
    checkOutput("abort mem_we drop", bus.mem_we, 0);
    checkOutput("abort gnt", bus.gnt, 0);
    checkOutput("abort brk_active", bus.brk_active, 0);
    done_count = done_count;
    we_start = done_count;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("abort no done", done_count - we_start, 0);
    checkOutput("abort WC untouched", mem[15'o00030], 12'o7777);
    checkOutput("abort CA untouched", mem[15'o00031], 12'o0477);
    checkOutput("abort data untouched", mem[15'o20500], 12'o1111);
    checkOutput("idle after abort", bus.brk_active, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Safety net in case a wait loop is ever bypassed
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
